// File: rtl/rename_freelist_ctrl_pkg.sv
// Shared rename constants: register-index widths, free-list depth and pointer
// geometry, plus a small helper used by both the free list and its controller.
package rename_freelist_ctrl_pkg;

  localparam int PREG_W   = 6;   // physical register index width
  localparam int AREG_W   = 5;   // architectural register index width
  localparam int FL_DEPTH = 32;  // free-list entries
  localparam int FL_IDX_W = 5;   // free-list index bits
  localparam int FL_PTR_W = 6;   // index bits + 1 wrap bit

  // Number of asserted flags out of two (0..2).
  function automatic logic [1:0] cnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical registers with 2-pop / 2-push per cycle.
// Ports:
//   clock, reset_n            clock, async active-low reset
//   i_pop_cnt                 entries consumed from head this cycle (0..2)
//   i_push0_*/i_push1_*       returned pregs; push0 lands first at tail
//   o_peek0 / o_peek1         combinational view of entries head, head+1
//   o_head / o_tail / o_count pointer and occupancy state
module rename_freelist
  import rename_freelist_ctrl_pkg::*;
#(
  parameter int PREG_W   = rename_freelist_ctrl_pkg::PREG_W,
  parameter int FL_DEPTH = rename_freelist_ctrl_pkg::FL_DEPTH,
  localparam int IDX_W   = $clog2(FL_DEPTH),
  localparam int PTR_W   = IDX_W + 1,
  localparam int CNT_W   = $clog2(FL_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        i_pop_cnt,
  input  logic              i_push0_valid,
  input  logic [PREG_W-1:0] i_push0_preg,
  input  logic              i_push1_valid,
  input  logic [PREG_W-1:0] i_push1_preg,
  output logic [PREG_W-1:0] o_peek0,
  output logic [PREG_W-1:0] o_peek1,
  output logic [PTR_W-1:0]  o_head,
  output logic [PTR_W-1:0]  o_tail,
  output logic [CNT_W-1:0]  o_count
);

  logic [PREG_W-1:0] r_fl [FL_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [1:0]        w_push_cnt;
  logic [PTR_W-1:0]  w_head_p1;
  logic [PTR_W-1:0]  w_push1_ptr;
  logic [CNT_W-1:0]  w_count_next;
  logic [CNT_W:0]    w_level_ext;

  assign w_push_cnt   = cnt2(i_push0_valid, i_push1_valid);
  assign w_head_p1    = r_head + PTR_W'(1);
  // push1 packs directly behind push0 when both are present
  assign w_push1_ptr  = r_tail + PTR_W'(i_push0_valid);
  assign w_count_next = r_count + CNT_W'(w_push_cnt) - CNT_W'(i_pop_cnt);
  assign w_level_ext  = {1'b0, r_count} + (CNT_W+1)'(w_push_cnt) - (CNT_W+1)'(i_pop_cnt);

  assign o_peek0 = r_fl[r_head[IDX_W-1:0]];
  assign o_peek1 = r_fl[w_head_p1[IDX_W-1:0]];
  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_count = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_fl[i] <= PREG_W'(FL_DEPTH + i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(FL_DEPTH);
    end else begin
      if (i_push0_valid) r_fl[r_tail[IDX_W-1:0]]      <= i_push0_preg;
      if (i_push1_valid) r_fl[w_push1_ptr[IDX_W-1:0]] <= i_push1_preg;
      r_head  <= r_head + PTR_W'(i_pop_cnt);
      r_tail  <= r_tail + PTR_W'(w_push_cnt);
      r_count <= w_count_next;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    w_level_ext <= (CNT_W+1)'(FL_DEPTH));

  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    CNT_W'(i_pop_cnt) <= r_count);

endmodule

// File: rtl/rename_freelist_ctrl.sv
// Two-wide register rename stage: allocates new pregs from the free list,
// resolves intra-group dependencies, issues RAT writes and registers the
// renamed group behind a valid/ready handshake.
// Ports:
//   clock, reset_n                     clock, async active-low reset
//   in_valid / in_ready                decoded group handshake
//   instrN_* (N=0,1)                   decode fields and RAT read data
//   instrN_rat_rename_*                RAT write requests (combinational on fire)
//   commitN_free_*                     pregs returned by commit / ROB recovery
//   flush                              pipeline redirect
//   out_valid / out_ready              renamed group handshake
//   out_instrN_*                       registered renamed operands
module rename_freelist_ctrl
  import rename_freelist_ctrl_pkg::*;
#(
  parameter int PREG_W   = rename_freelist_ctrl_pkg::PREG_W,
  parameter int AREG_W   = rename_freelist_ctrl_pkg::AREG_W,
  parameter int FL_DEPTH = rename_freelist_ctrl_pkg::FL_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              instr0_need_to_wb,
  input  logic [AREG_W-1:0] instr0_rd,
  input  logic              instr0_src1_is_reg,
  input  logic [AREG_W-1:0] instr0_rs1,
  input  logic              instr0_src2_is_reg,
  input  logic [AREG_W-1:0] instr0_rs2,
  input  logic              instr1_need_to_wb,
  input  logic [AREG_W-1:0] instr1_rd,
  input  logic              instr1_src1_is_reg,
  input  logic [AREG_W-1:0] instr1_rs1,
  input  logic              instr1_src2_is_reg,
  input  logic [AREG_W-1:0] instr1_rs2,
  input  logic [PREG_W-1:0] instr0_rat_prs1,
  input  logic [PREG_W-1:0] instr0_rat_prs2,
  input  logic [PREG_W-1:0] instr0_rat_prd,
  input  logic [PREG_W-1:0] instr1_rat_prs1,
  input  logic [PREG_W-1:0] instr1_rat_prs2,
  input  logic [PREG_W-1:0] instr1_rat_prd,
  output logic              instr0_rat_rename_valid,
  output logic [AREG_W-1:0] instr0_rat_rename_addr,
  output logic [PREG_W-1:0] instr0_rat_rename_data,
  output logic              instr1_rat_rename_valid,
  output logic [AREG_W-1:0] instr1_rat_rename_addr,
  output logic [PREG_W-1:0] instr1_rat_rename_data,
  input  logic              commit0_free_valid,
  input  logic [PREG_W-1:0] commit0_free_preg,
  input  logic              commit1_free_valid,
  input  logic [PREG_W-1:0] commit1_free_preg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_instr0_prs1,
  output logic [PREG_W-1:0] out_instr0_prs2,
  output logic [PREG_W-1:0] out_instr0_prd,
  output logic [PREG_W-1:0] out_instr0_old_prd,
  output logic [PREG_W-1:0] out_instr1_prs1,
  output logic [PREG_W-1:0] out_instr1_prs2,
  output logic [PREG_W-1:0] out_instr1_prd,
  output logic [PREG_W-1:0] out_instr1_old_prd
);

  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(FL_DEPTH + 1);

  logic              w_alloc0, w_alloc1, w_same_rd, w_fire;
  logic [1:0]        w_pop_cnt;
  logic [PREG_W-1:0] w_peek0, w_peek1, w_prd0, w_prd1;
  logic [PTR_W-1:0]  w_head, w_tail;
  logic [CNT_W-1:0]  w_count;
  logic [PREG_W-1:0] w_prs1_0, w_prs2_0, w_new_prd0, w_old0;
  logic [PREG_W-1:0] w_prs1_1, w_prs2_1, w_new_prd1, w_old1;

  logic              r_out_valid;
  logic [PREG_W-1:0] r_prs1_0, r_prs2_0, r_prd0, r_old0;
  logic [PREG_W-1:0] r_prs1_1, r_prs2_1, r_prd1, r_old1;

  rename_freelist #(.PREG_W(PREG_W), .FL_DEPTH(FL_DEPTH)) u_freelist (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_pop_cnt     (w_pop_cnt),
    .i_push0_valid (commit0_free_valid),
    .i_push0_preg  (commit0_free_preg),
    .i_push1_valid (commit1_free_valid),
    .i_push1_preg  (commit1_free_preg),
    .o_peek0       (w_peek0),
    .o_peek1       (w_peek1),
    .o_head        (w_head),
    .o_tail        (w_tail),
    .o_count       (w_count)
  );

  assign w_alloc0  = instr0_need_to_wb & (instr0_rd != '0);
  assign w_alloc1  = instr1_need_to_wb & (instr1_rd != '0);
  assign w_same_rd = w_alloc0 & w_alloc1 & (instr0_rd == instr1_rd);

  // reset_n gating keeps the handshake closed while reset is asserted
  assign in_ready  = reset_n & (w_count >= CNT_W'(2)) & (~r_out_valid | out_ready) & ~flush;
  assign w_fire    = in_valid & in_ready;
  assign w_pop_cnt = w_fire ? cnt2(w_alloc0, w_alloc1) : 2'd0;

  // instr1 takes the head entry when instr0 does not allocate
  assign w_prd0 = w_peek0;
  assign w_prd1 = w_alloc0 ? w_peek1 : w_peek0;

  // instr0's write is dropped on equal rd so the younger mapping is the one kept
  assign instr0_rat_rename_valid = w_fire & w_alloc0 & ~w_same_rd;
  assign instr0_rat_rename_addr  = instr0_rd;
  assign instr0_rat_rename_data  = w_prd0;
  assign instr1_rat_rename_valid = w_fire & w_alloc1;
  assign instr1_rat_rename_addr  = instr1_rd;
  assign instr1_rat_rename_data  = w_prd1;

  assign w_prs1_0   = instr0_src1_is_reg ? instr0_rat_prs1 : '0;
  assign w_prs2_0   = instr0_src2_is_reg ? instr0_rat_prs2 : '0;
  assign w_new_prd0 = w_alloc0 ? w_prd0 : '0;
  assign w_old0     = w_alloc0 ? instr0_rat_prd : '0;

  // RAW bypass: instr1 sources written by instr0 see instr0's new preg
  assign w_prs1_1 = !instr1_src1_is_reg ? '0 :
                    (w_alloc0 && (instr1_rs1 == instr0_rd)) ? w_prd0 : instr1_rat_prs1;
  assign w_prs2_1 = !instr1_src2_is_reg ? '0 :
                    (w_alloc0 && (instr1_rs2 == instr0_rd)) ? w_prd0 : instr1_rat_prs2;
  assign w_new_prd1 = w_alloc1 ? w_prd1 : '0;
  assign w_old1     = !w_alloc1 ? '0 : (w_same_rd ? w_prd0 : instr1_rat_prd);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_prs1_0 <= '0; r_prs2_0 <= '0; r_prd0 <= '0; r_old0 <= '0;
      r_prs1_1 <= '0; r_prs2_1 <= '0; r_prd1 <= '0; r_old1 <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_prs1_0 <= w_prs1_0; r_prs2_0 <= w_prs2_0; r_prd0 <= w_new_prd0; r_old0 <= w_old0;
      r_prs1_1 <= w_prs1_1; r_prs2_1 <= w_prs2_1; r_prd1 <= w_new_prd1; r_old1 <= w_old1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid          = r_out_valid;
  assign out_instr0_prs1    = r_prs1_0;
  assign out_instr0_prs2    = r_prs2_0;
  assign out_instr0_prd     = r_prd0;
  assign out_instr0_old_prd = r_old0;
  assign out_instr1_prs1    = r_prs1_1;
  assign out_instr1_prs2    = r_prs2_1;
  assign out_instr1_prd     = r_prd1;
  assign out_instr1_old_prd = r_old1;

  // head and tail agree with count modulo the depth (count = depth when full)
  a_ptr_consistent: assert property (@(posedge clock) disable iff (!reset_n)
    ((w_tail - w_head) & PTR_W'(FL_DEPTH - 1)) == (PTR_W'(w_count) & PTR_W'(FL_DEPTH - 1)));

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
module tb_rename_freelist_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_valid, in_ready;
  logic       instr0_need_to_wb, instr0_src1_is_reg, instr0_src2_is_reg;
  logic [4:0] instr0_rd, instr0_rs1, instr0_rs2;
  logic       instr1_need_to_wb, instr1_src1_is_reg, instr1_src2_is_reg;
  logic [4:0] instr1_rd, instr1_rs1, instr1_rs2;
  logic [5:0] instr0_rat_prs1, instr0_rat_prs2, instr0_rat_prd;
  logic [5:0] instr1_rat_prs1, instr1_rat_prs2, instr1_rat_prd;
  logic       instr0_rat_rename_valid, instr1_rat_rename_valid;
  logic [4:0] instr0_rat_rename_addr, instr1_rat_rename_addr;
  logic [5:0] instr0_rat_rename_data, instr1_rat_rename_data;
  logic       commit0_free_valid, commit1_free_valid;
  logic [5:0] commit0_free_preg, commit1_free_preg;
  logic       flush, out_valid, out_ready;
  logic [5:0] out_instr0_prs1, out_instr0_prs2, out_instr0_prd, out_instr0_old_prd;
  logic [5:0] out_instr1_prs1, out_instr1_prs2, out_instr1_prd, out_instr1_old_prd;

  rename_freelist_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr0_need_to_wb(instr0_need_to_wb), .instr0_rd(instr0_rd),
    .instr0_src1_is_reg(instr0_src1_is_reg), .instr0_rs1(instr0_rs1),
    .instr0_src2_is_reg(instr0_src2_is_reg), .instr0_rs2(instr0_rs2),
    .instr1_need_to_wb(instr1_need_to_wb), .instr1_rd(instr1_rd),
    .instr1_src1_is_reg(instr1_src1_is_reg), .instr1_rs1(instr1_rs1),
    .instr1_src2_is_reg(instr1_src2_is_reg), .instr1_rs2(instr1_rs2),
    .instr0_rat_prs1(instr0_rat_prs1), .instr0_rat_prs2(instr0_rat_prs2),
    .instr0_rat_prd(instr0_rat_prd),
    .instr1_rat_prs1(instr1_rat_prs1), .instr1_rat_prs2(instr1_rat_prs2),
    .instr1_rat_prd(instr1_rat_prd),
    .instr0_rat_rename_valid(instr0_rat_rename_valid),
    .instr0_rat_rename_addr(instr0_rat_rename_addr),
    .instr0_rat_rename_data(instr0_rat_rename_data),
    .instr1_rat_rename_valid(instr1_rat_rename_valid),
    .instr1_rat_rename_addr(instr1_rat_rename_addr),
    .instr1_rat_rename_data(instr1_rat_rename_data),
    .commit0_free_valid(commit0_free_valid), .commit0_free_preg(commit0_free_preg),
    .commit1_free_valid(commit1_free_valid), .commit1_free_preg(commit1_free_preg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr0_prs1(out_instr0_prs1), .out_instr0_prs2(out_instr0_prs2),
    .out_instr0_prd(out_instr0_prd), .out_instr0_old_prd(out_instr0_old_prd),
    .out_instr1_prs1(out_instr1_prs1), .out_instr1_prs2(out_instr1_prs2),
    .out_instr1_prd(out_instr1_prd), .out_instr1_old_prd(out_instr1_old_prd)
  );

  always #5 clock = ~clock;

  typedef struct {
    int rst, iv, ordy, fl;
    int wb0, rd0, s1r0, rs1_0, s2r0, rs2_0;
    int wb1, rd1, s1r1, rs1_1, s2r1, rs2_1;
    int c0v, c0p, c1v, c1p;
    int e_rdy, e_w0v, e_w0d, e_w1v, e_w1d, e_ov;
    int e_prs1_0, e_prs2_0, e_prd0, e_old0;
    int e_prs1_1, e_prs2_1, e_prd1, e_old1;
    int e_cnt;
  } vec_t;

  vec_t vecs[9];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 0; out_ready = 1; flush = 0;
    instr0_need_to_wb = 0; instr0_rd = 0; instr0_src1_is_reg = 0; instr0_rs1 = 0;
    instr0_src2_is_reg = 0; instr0_rs2 = 0;
    instr1_need_to_wb = 0; instr1_rd = 0; instr1_src1_is_reg = 0; instr1_rs1 = 0;
    instr1_src2_is_reg = 0; instr1_rs2 = 0;
    commit0_free_valid = 0; commit0_free_preg = 0;
    commit1_free_valid = 0; commit1_free_preg = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid = v.iv[0]; out_ready = v.ordy[0]; flush = v.fl[0];
    instr0_need_to_wb = v.wb0[0]; instr0_rd = 5'(v.rd0);
    instr0_src1_is_reg = v.s1r0[0]; instr0_rs1 = 5'(v.rs1_0);
    instr0_src2_is_reg = v.s2r0[0]; instr0_rs2 = 5'(v.rs2_0);
    instr1_need_to_wb = v.wb1[0]; instr1_rd = 5'(v.rd1);
    instr1_src1_is_reg = v.s1r1[0]; instr1_rs1 = 5'(v.rs1_1);
    instr1_src2_is_reg = v.s2r1[0]; instr1_rs2 = 5'(v.rs2_1);
    commit0_free_valid = v.c0v[0]; commit0_free_preg = 6'(v.c0p);
    commit1_free_valid = v.c1v[0]; commit1_free_preg = 6'(v.c1p);
  endtask

  task automatic pulse_reset();
    drive_idle();
    reset_n = 0;
    @(posedge clock); #1;
    reset_n = 1;
  endtask

  initial begin
    // fixed RAT read data used by every vector
    instr0_rat_prs1 = 11; instr0_rat_prs2 = 14; instr0_rat_prd = 20;
    instr1_rat_prs1 = 12; instr1_rat_prs2 = 17; instr1_rat_prd = 21;

    //            rst iv rdy fl | wb0 rd0 s1 rs1 s2 rs2 | wb1 rd1 s1 rs1 s2 rs2 | c0v c0p c1v c1p | rdy w0v w0d w1v w1d ov | prs1_0 prs2_0 prd0 old0 | prs1_1 prs2_1 prd1 old1 | cnt
    vecs[0] = '{1,1,1,0, 1,5,1,1,0,0,   1,6,1,1,0,0,   0,0,0,0,  1,1,32,1,33,1, 11,0,32,20, 12,0,33,21, 30};
    vecs[1] = '{1,1,1,0, 1,7,1,3,1,2,   1,7,1,7,0,0,   0,0,0,0,  1,0,32,1,33,1, 11,14,32,20, 32,0,33,32, 30};
    vecs[2] = '{0,1,1,0, 1,0,0,0,0,0,   1,8,1,0,0,0,   0,0,0,0,  1,0,0,1,34,1,  0,0,0,0, 12,0,34,21, 29};
    vecs[3] = '{0,0,1,0, 0,0,0,0,0,0,   0,0,0,0,0,0,   0,0,0,0,  1,0,0,0,0,0,   0,0,0,0, 12,0,34,21, 29};
    vecs[4] = '{0,1,0,0, 0,4,1,4,0,0,   1,9,0,0,1,4,   0,0,0,0,  1,0,0,1,35,1,  11,0,0,0, 0,17,35,21, 28};
    vecs[5] = '{0,1,1,0, 1,10,0,0,0,0,  1,11,1,5,1,10, 1,50,0,0, 1,1,36,1,37,1, 0,0,36,20, 12,36,37,21, 27};
    vecs[6] = '{0,1,0,0, 1,12,0,0,0,0,  1,13,0,0,0,0,  0,0,0,0,  0,0,0,0,0,1,   0,0,36,20, 12,36,37,21, 27};
    vecs[7] = '{0,1,0,1, 1,12,0,0,0,0,  1,13,0,0,0,0,  0,0,1,51, 0,0,0,0,0,0,   0,0,36,20, 12,36,37,21, 28};
    vecs[8] = '{0,1,0,0, 1,1,0,0,0,0,   0,0,0,0,0,0,   0,0,0,0,  1,1,38,0,0,1,  0,0,38,20, 0,0,0,0, 27};

    // reset asserted with a group offered: nothing may leave the block
    drive_idle();
    in_valid = 1; instr0_need_to_wb = 1; instr0_rd = 5;
    #1 reset_n = 0;
    #2;
    chk("rst in_ready", in_ready, 0);
    chk("rst rat0_valid", instr0_rat_rename_valid, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst count", dut.u_freelist.o_count, 32);
    chk("rst out_prd0", out_instr0_prd, 0);
    @(posedge clock); #1;
    reset_n = 1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst != 0) pulse_reset();
      drive_vec(vecs[i]);
      #3;
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("v%0d rat0_valid", i), instr0_rat_rename_valid, vecs[i].e_w0v);
      chk($sformatf("v%0d rat1_valid", i), instr1_rat_rename_valid, vecs[i].e_w1v);
      if (vecs[i].e_w0v != 0) begin
        chk($sformatf("v%0d rat0_addr", i), instr0_rat_rename_addr, vecs[i].rd0);
        chk($sformatf("v%0d rat0_data", i), instr0_rat_rename_data, vecs[i].e_w0d);
      end
      if (vecs[i].e_w1v != 0) begin
        chk($sformatf("v%0d rat1_addr", i), instr1_rat_rename_addr, vecs[i].rd1);
        chk($sformatf("v%0d rat1_data", i), instr1_rat_rename_data, vecs[i].e_w1d);
      end
      @(posedge clock); #1;
      chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d prs1_0", i), out_instr0_prs1, vecs[i].e_prs1_0);
      chk($sformatf("v%0d prs2_0", i), out_instr0_prs2, vecs[i].e_prs2_0);
      chk($sformatf("v%0d prd0", i), out_instr0_prd, vecs[i].e_prd0);
      chk($sformatf("v%0d old_prd0", i), out_instr0_old_prd, vecs[i].e_old0);
      chk($sformatf("v%0d prs1_1", i), out_instr1_prs1, vecs[i].e_prs1_1);
      chk($sformatf("v%0d prs2_1", i), out_instr1_prs2, vecs[i].e_prs2_1);
      chk($sformatf("v%0d prd1", i), out_instr1_prd, vecs[i].e_prd1);
      chk($sformatf("v%0d old_prd1", i), out_instr1_old_prd, vecs[i].e_old1);
      chk($sformatf("v%0d count", i), dut.u_freelist.o_count, vecs[i].e_cnt);
    end

    // drain the free list with 16 full groups, then a 17th must be held
    pulse_reset();
    in_valid = 1; out_ready = 1;
    instr0_need_to_wb = 1; instr0_rd = 1;
    instr1_need_to_wb = 1; instr1_rd = 2;
    for (int k = 0; k < 16; k++) begin
      #3;
      chk($sformatf("drain%0d in_ready", k), in_ready, 1);
      chk($sformatf("drain%0d rat0_data", k), instr0_rat_rename_data, 32 + 2*k);
      chk($sformatf("drain%0d rat1_data", k), instr1_rat_rename_data, 33 + 2*k);
      @(posedge clock); #1;
    end
    chk("drain count", dut.u_freelist.o_count, 0);
    chk("drain last prd0", out_instr0_prd, 62);
    chk("drain last prd1", out_instr1_prd, 63);
    for (int k = 0; k < 2; k++) begin
      #3;
      chk($sformatf("held%0d in_ready", k), in_ready, 0);
      chk($sformatf("held%0d rat0_valid", k), instr0_rat_rename_valid, 0);
      chk($sformatf("held%0d rat1_valid", k), instr1_rat_rename_valid, 0);
      @(posedge clock); #1;
      chk($sformatf("held%0d count", k), dut.u_freelist.o_count, 0);
      chk($sformatf("held%0d out_valid", k), out_valid, 0);
    end

    // count=1 plus a same-cycle free: not ready now, fires next cycle
    in_valid = 0;
    commit0_free_valid = 1; commit0_free_preg = 41;
    @(posedge clock); #1;
    commit0_free_preg = 40; in_valid = 1;
    #3;
    chk("c1 count", dut.u_freelist.o_count, 1);
    chk("c1 in_ready", in_ready, 0);
    chk("c1 rat0_valid", instr0_rat_rename_valid, 0);
    @(posedge clock); #1;
    commit0_free_valid = 0;
    #3;
    chk("c2 count", dut.u_freelist.o_count, 2);
    chk("c2 in_ready", in_ready, 1);
    chk("c2 rat0_data", instr0_rat_rename_data, 41);
    chk("c2 rat1_data", instr1_rat_rename_data, 40);
    @(posedge clock); #1;
    in_valid = 0; out_ready = 0;
    chk("c2 post count", dut.u_freelist.o_count, 0);
    chk("c2 out_valid", out_valid, 1);
    chk("c2 out_prd0", out_instr0_prd, 41);
    chk("c2 out_prd1", out_instr1_prd, 40);

    // reset mid-operation discards the held group immediately
    #1 reset_n = 0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_prd0", out_instr0_prd, 0);
    chk("midrst count", dut.u_freelist.o_count, 32);
    chk("midrst in_ready", in_ready, 0);
    @(posedge clock); #1;
    reset_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_freelist_ctrl.md
RENAME_FREELIST_CTRL -- requirements
Module: rename_freelist_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  PREG_W, 6, physical register index width
  AREG_W, 5, architectural register index width
  FL_DEPTH, 32, free-list entries
REQ-002 Ports, one per line (name  direction  width  meaning):
  clock  in  1  clock
  reset_n  in  1  reset, asynchronous, active-low
  in_valid / in_ready  in / out  1 / 1  decoded 2-instr group handshake
  instrN_need_to_wb, instrN_rd, instrN_src1_is_reg, instrN_rs1, instrN_src2_is_reg, instrN_rs2  in  1/5/1/5/1/5  decode fields, N=0,1
  instrN_rat_prs1 / instrN_rat_prs2 / instrN_rat_prd  in  6 each  RAT read data, N=0,1
  instrN_rat_rename_valid / _addr / _data  out  1/5/6  RAT write request, N=0,1
  commitN_free_valid / commitN_free_preg  in  1/6  preg returns, N=0,1
  flush  in  1  pipeline redirect
  out_valid / out_ready  out / in  1 / 1  renamed-group handshake
  out_instrN_prs1 / _prs2 / _prd / _old_prd  out  6 each  renamed operands, N=0,1

Function
REQ-003 allocN = instrN_need_to_wb & (instrN_rd != 0); x0 never allocates.
REQ-004 in_ready = (count >= 2) & (~out_valid | out_ready) & ~flush; independent of alloc flags.
REQ-005 fire = in_valid & in_ready; free list pops alloc0+alloc1 entries on fire, else none.
REQ-006 New prd: instr0 = fl[head]; instr1 = fl[head + alloc0], index mod 32.
REQ-007 Bypass: instr1 prs1 = instr0 new prd when alloc0 & instr1_src1_is_reg & rs1==instr0_rd; same for prs2.
REQ-008 instr1 old_prd = instr0 new prd when alloc0 & alloc1 & equal rd; else RAT value.
REQ-009 RAT writes are combinational on fire: instrN_rat_rename_valid = fire & allocN, addr = rd, data = new prd.
REQ-010 When alloc0 & alloc1 and the rds are equal, instr0 write is suppressed so instr1's mapping lands.
REQ-011 Frees push commit0 first, then commit1, at tail every cycle, including during flush.
REQ-012 count_next = count - pops + pushes, computed in the same cycle; simultaneous pop and push are legal.
REQ-013 Overflow (count + pushes - pops > 32) is illegal and SHALL be covered by an assertion.
REQ-014 Output register updates on fire, with 1-cycle latency.
  - Non-allocating slot: prd = 0, old_prd = 0.
  - Non-reg source: prs = 0.
REQ-015 out_valid clears on out_ready without a new fire; flush clears out_valid next cycle with top priority.
REQ-016 Flush does not roll back head; recovery of unretired pregs is the ROB's job, via the free ports.

Reset
REQ-017 On reset_n low, asynchronously:
  - fl[i] = 32+i
  - head = 0, tail = 0, count = 32
  - out_valid = 0; all out_* data = 0
REQ-018 During reset, rat_rename_valid = 0 and in_ready = 0; a reset mid-operation discards any in-flight group.

Structure
REQ-019 PREG_W, AREG_W, FL_DEPTH and the free-list pointer width (6 bits: 5 index + 1 wrap) SHALL live in a shared rename package.
REQ-020 The circular buffer SHALL be a sub-module, rename_freelist, providing:
  - 2-pop / 2-push
  - head/tail/count
  - combinational peek of entries head and head+1

Verification
REQ-021 Reset, then a group with rd0=5, rd1=6, both wb -> RAT writes (5,32) and (6,33); out prds 32/33; count 30.
REQ-022 rd0=rd1=7, instr1 rs1=7 -> instr0 RAT write suppressed; instr1 writes (7,33); out_instr1_prs1=32 and old_prd=32.
REQ-023 16 back-to-back full groups with no frees -> count reaches 0; in_ready=0 once count<2; the 17th group is held.
REQ-024 count=1 with commit0_free_preg=40 and an in_valid group -> in_ready=0 that cycle; next cycle count=2 and the group fires.
REQ-025 flush while out_valid=1 & out_ready=0 -> out_valid=0 next cycle; no RAT write; a concurrent commit free is still pushed.
REQ-026 rd0=0 with need_to_wb=1 -> no alloc, no RAT write; instr1 takes fl[head].
